// File: rtl/fp_mul_sequencer.sv
// Multi-cycle IEEE-754 single-precision multiplier controller: one shared 9x9 multiplier
// issues six 3-way Karatsuba partial products, then combines, normalises and truncates.
module fp_mul_sequencer #(
    parameter int unsigned BIAS = 127,
    parameter int unsigned LAT  = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic        ovf_o,
    output logic        udf_o,
    output logic        busy_o
);

    // UNPACK + COMBINE + NORM take three of the LAT cycles; the rest are multiplier steps.
    localparam logic [2:0] MulLast = 3'(LAT - 4);

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StMul,
        StCombine,
        StNorm,
        StDone
    } state_e;

    state_e             state_q;
    logic [31:0]        a_q, b_q;
    logic [23:0]        man_a_q, man_b_q;
    logic               sg_q;
    logic signed [9:0]  esum_q;
    logic               nan_q, inf_q, zero_q;
    logic [2:0]         cnt_q;
    logic [17:0]        h0_q, h1_q, h2_q, g0_q, g1_q, g2_q;
    logic [47:0]        prod_q;
    logic [31:0]        result_q;
    logic               ovf_q, udf_q, out_valid_q, in_ready_q, busy_q;

    logic [7:0]         ea, eb;
    logic [22:0]        fa, fb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [9:0]         esum;
    logic [8:0]         op_a, op_b;
    logic [17:0]        mul_out;
    logic [47:0]        t1, t2, t3, p_comb;
    logic signed [9:0]  e_fin;
    logic [22:0]        mant;
    logic [31:0]        norm_res;
    logic               norm_ovf, norm_udf;

    always_comb begin
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        fa     = a_q[22:0];
        fb     = b_q[22:0];
        a_nan  = (ea == 8'hFF) && (fa != 23'h0);
        b_nan  = (eb == 8'hFF) && (fb != 23'h0);
        a_inf  = (ea == 8'hFF) && (fa == 23'h0);
        b_inf  = (eb == 8'hFF) && (fb == 23'h0);
        // Denormals are flushed, so they classify as zero.
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        esum   = {2'b00, ea} + {2'b00, eb} - 10'(BIAS);
    end

    always_comb begin
        op_a = 9'h0;
        op_b = 9'h0;
        case (cnt_q)
            3'd0: begin op_a = {1'b0, man_a_q[7:0]};   op_b = {1'b0, man_b_q[7:0]};   end
            3'd1: begin op_a = {1'b0, man_a_q[15:8]};  op_b = {1'b0, man_b_q[15:8]};  end
            3'd2: begin op_a = {1'b0, man_a_q[23:16]}; op_b = {1'b0, man_b_q[23:16]}; end
            3'd3: begin
                op_a = {1'b0, man_a_q[7:0]} + {1'b0, man_a_q[15:8]};
                op_b = {1'b0, man_b_q[7:0]} + {1'b0, man_b_q[15:8]};
            end
            3'd4: begin
                op_a = {1'b0, man_a_q[7:0]} + {1'b0, man_a_q[23:16]};
                op_b = {1'b0, man_b_q[7:0]} + {1'b0, man_b_q[23:16]};
            end
            3'd5: begin
                op_a = {1'b0, man_a_q[15:8]} + {1'b0, man_a_q[23:16]};
                op_b = {1'b0, man_b_q[15:8]} + {1'b0, man_b_q[23:16]};
            end
            default: begin op_a = 9'h0; op_b = 9'h0; end
        endcase
        mul_out = op_a * op_b;
    end

    // Subtraction order keeps every intermediate non-negative.
    always_comb begin
        t3     = 48'(g2_q) - 48'(h1_q) - 48'(h2_q);
        t2     = 48'(g1_q) + 48'(h1_q) - 48'(h0_q) - 48'(h2_q);
        t1     = 48'(g0_q) - 48'(h0_q) - 48'(h1_q);
        p_comb = (48'(h2_q) << 32) + (t3 << 24) + (t2 << 16) + (t1 << 8) + 48'(h0_q);
    end

    always_comb begin
        e_fin    = prod_q[47] ? esum_q + 10'sd1 : esum_q;
        mant     = prod_q[47] ? prod_q[46:24] : prod_q[45:23];
        norm_ovf = 1'b0;
        norm_udf = 1'b0;
        if (nan_q) begin
            norm_res = 32'h7FC0_0000;
        end else if (inf_q) begin
            norm_res = {sg_q, 8'hFF, 23'h0};
        end else if (zero_q) begin
            norm_res = {sg_q, 31'h0};
        end else if (e_fin >= 10'sd255) begin
            norm_res = {sg_q, 8'hFF, 23'h0};
            norm_ovf = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            norm_res = {sg_q, 31'h0};
            norm_udf = 1'b1;
        end else begin
            norm_res = {sg_q, e_fin[7:0], mant};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            man_a_q     <= 24'h0;
            man_b_q     <= 24'h0;
            sg_q        <= 1'b0;
            esum_q      <= 10'sd0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
            cnt_q       <= 3'd0;
            h0_q        <= 18'h0;
            h1_q        <= 18'h0;
            h2_q        <= 18'h0;
            g0_q        <= 18'h0;
            g1_q        <= 18'h0;
            g2_q        <= 18'h0;
            prod_q      <= 48'h0;
            result_q    <= 32'h0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i && in_ready_q) begin
                        a_q        <= a_i;
                        b_q        <= b_i;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StUnpack;
                    end
                end
                StUnpack: begin
                    man_a_q <= {ea != 8'h00, fa};
                    man_b_q <= {eb != 8'h00, fb};
                    sg_q    <= a_q[31] ^ b_q[31];
                    esum_q  <= esum;
                    nan_q   <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
                    inf_q   <= a_inf || b_inf;
                    zero_q  <= a_zero || b_zero;
                    cnt_q   <= 3'd0;
                    state_q <= StMul;
                end
                StMul: begin
                    case (cnt_q)
                        3'd0:    h0_q <= mul_out;
                        3'd1:    h1_q <= mul_out;
                        3'd2:    h2_q <= mul_out;
                        3'd3:    g0_q <= mul_out;
                        3'd4:    g1_q <= mul_out;
                        default: g2_q <= mul_out;
                    endcase
                    if (cnt_q == MulLast) begin
                        state_q <= StCombine;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                StCombine: begin
                    prod_q  <= p_comb;
                    state_q <= StNorm;
                end
                StNorm: begin
                    result_q    <= norm_res;
                    ovf_q       <= norm_ovf;
                    udf_q       <= norm_udf;
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign ovf_o       = ovf_q;
    assign udf_o       = udf_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Bench for fp_mul_sequencer: directed corner cases plus random operands checked against
// a plain-arithmetic single-precision multiply model (truncation, flush-to-zero).
module tb_fp_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] a_i, b_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        ovf_o, udf_o, busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    fp_mul_sequencer #(.BIAS(127), .LAT(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .result_o   (result_o),
        .ovf_o      (ovf_o),
        .udf_o      (udf_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic o, output logic u);
        int          ex, ey, e;
        logic [22:0] mx, my;
        logic        s, xn, yn, xi, yi, xz, yz;
        logic [63:0] p, m;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = x[22:0];
        my = y[22:0];
        s  = x[31] ^ y[31];
        xn = (ex == 255) && (mx != 0);
        yn = (ey == 255) && (my != 0);
        xi = (ex == 255) && (mx == 0);
        yi = (ey == 255) && (my == 0);
        xz = (ex == 0);
        yz = (ey == 0);
        o  = 1'b0;
        u  = 1'b0;
        if (xn || yn || (xi && yz) || (yi && xz)) begin
            r = 32'h7FC0_0000;
        end else if (xi || yi) begin
            r = {s, 8'hFF, 23'h0};
        end else if (xz || yz) begin
            r = {s, 31'h0};
        end else begin
            p = 64'({1'b1, mx}) * 64'({1'b1, my});
            e = ex + ey - 127;
            if (p >= 64'h0000_8000_0000_0000) begin
                e = e + 1;
                m = p >> 24;
            end else begin
                m = p >> 23;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'h0};
                o = 1'b1;
            end else if (e <= 0) begin
                r = {s, 31'h0};
                u = 1'b1;
            end else begin
                r = {s, 8'(e), m[22:0]};
            end
        end
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: v[30:23] = 8'hFF;
            1: v[30:23] = 8'h00;
            2: v[30:0]  = 31'h0;
            3, 4, 5: v[30:23] = 8'($urandom_range(100, 154));
            default: ;
        endcase
        return v;
    endfunction

    // Called at a negedge; issues one op, checks latency/result, holds out_ready low for hold cycles.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input int hold);
        logic [31:0] er, held;
        logic        eo, eu;
        int          n;
        ref_mul(av, bv, er, eo, eu);
        n = 0;
        while (!in_ready_o && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_idle", 32'(in_ready_o), 32'd1);
        a_i        = av;
        b_i        = bv;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        a_i        = $urandom;
        b_i        = $urandom;
        @(negedge clk);
        chk("busy_after_accept", 32'(busy_o), 32'd1);
        chk("in_ready_while_busy", 32'(in_ready_o), 32'd0);
        n = 0;
        while (!out_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'd9);
        chk("result", result_o, er);
        chk("ovf", 32'(ovf_o), 32'(eo));
        chk("udf", 32'(udf_o), 32'(eu));
        held = result_o;
        for (int i = 0; i < hold; i++) begin
            in_valid_i = 1'b1;
            a_i        = 32'h3F80_0000;
            b_i        = 32'h3F80_0000;
            @(negedge clk);
            chk("bp_result_held", result_o, held);
            chk("bp_out_valid", 32'(out_valid_o), 32'd1);
            chk("bp_in_ready", 32'(in_ready_o), 32'd0);
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
        chk("out_valid_drop", 32'(out_valid_o), 32'd0);
        chk("in_ready_back", 32'(in_ready_o), 32'd1);
        chk("no_accept_at_done", 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        a_i         = 32'h0;
        b_i         = 32'h0;
        #12;
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_ovf_udf", {30'h0, ovf_o, udf_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(32'h3F80_0000, 32'h3F80_0000, 0);
        chk("one_times_one", result_o, 32'h3F80_0000);
        do_op(32'h4040_0000, 32'hC020_0000, 0);
        chk("three_times_m2p5", result_o, 32'hC0F0_0000);
        do_op(32'h7F00_0000, 32'h7F00_0000, 0);
        chk("overflow_flag", {31'h0, ovf_o}, 32'd1);
        do_op(32'h0080_0000, 32'h3F00_0000, 0);
        chk("underflow_flag", {31'h0, udf_o}, 32'd1);
        do_op(32'h7F80_0000, 32'h8000_0000, 0);
        do_op(32'h7FC0_0001, 32'h3F80_0000, 0);
        do_op(32'h0000_0001, 32'h3F80_0000, 0);
        do_op(32'hFF80_0000, 32'h4000_0000, 0);
        do_op(32'h3FFF_FFFF, 32'h3FFF_FFFF, 0);
        do_op(32'h4040_0000, 32'hC020_0000, 5);

        // Abort mid-multiply: outputs must drop asynchronously.
        a_i        = 32'h4040_0000;
        b_i        = 32'h4040_0000;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid_o), 32'd0);
        chk("abort_in_ready", 32'(in_ready_o), 32'd1);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_result", result_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(32'h3F80_0000, 32'h3F80_0000, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(rnd_fp(), rnd_fp(), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
